core_ctrl_scb_cnt: RTL and testbench
====================================

# core_ctrl_scb_cnt

Counter-based register scoreboard for the issue stage. It generalises the single-bit busy scoreboard to per-register outstanding-write counters, multiple retire ports, a flush, and observability outputs. It sits between decode/issue and the writeback/retire paths, gating instruction emission on RAW (and optionally WAW) hazards.

## Interface
- NREG, 32, number of architectural registers tracked; index 0 is hardwired ready.
- IDX_W, 5, register index width; must satisfy 2^IDX_W >= NREG.
- CNT_W, 2, per-register counter width; max outstanding writes per register = 2^CNT_W-1.
- RET_PORTS, 2, number of independent retire ports.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- emit_valid  in  1  issue stage presents an instruction.
- rs1_vld / rs2_vld  in  1  source operand used.
- rs1_idx / rs2_idx  in  IDX_W  source register index.
- rd_vld  in  1  destination written.
- rd_idx  in  IDX_W  destination index.
- emit_ready  out  1  combinational; instruction may emit this cycle.
- ret_valid  in  RET_PORTS  per-port retire strobe.
- ret_idx  in  RET_PORTS*IDX_W  packed retire indices, port p at [p*IDX_W +: IDX_W].
- flush  in  1  pipeline flush; clears all outstanding state.
- stall_cause  out  3  combinational one-hot blocker: bit0 rs1, bit1 rs2, bit2 rd.
- busy_vec  out  NREG  registered; bit r = (cnt[r] != 0).
- pend_total  out  IDX_W+CNT_W  registered sum of all counters.
- err_underflow  out  1  registered sticky; retire seen on a zero counter.

## Operation
- State: cnt[r] for r in 1..NREG-1, CNT_W bits each; cnt[0] is not stored and reads as 0.
- Source check: rsN_ok = !rsN_vld || rsN_idx==0 || cnt[rsN_idx]==0.
- Destination check: rd_ok = !rd_vld || rd_idx==0 || cnt[rd_idx]==0 (see Configuration for the WAW variant).
- emit_ready = !flush && rs1_ok && rs2_ok && rd_ok. It is evaluated on pre-update counters; a retire in the same cycle does not unblock emission.
- Accept (fire) = emit_valid && emit_ready. On fire with rd_vld and rd_idx!=0, the increment to cnt[rd_idx] is 1.
- Retire: for each register, the decrement equals the number of ports with ret_valid set and ret_idx equal to that register. Retires to index 0 are ignored.
- Net update per register is cnt + inc - dec, computed in a single step. Emit and retire on the same register in one cycle cancel.
- Underflow: if dec > cnt + inc, the counter saturates at 0 and err_underflow sets, cleared only by rst.
- Overflow is prevented by rd_ok; the counter never exceeds 2^CNT_W-1.
- Flush: next state of every counter is 0. Emission is blocked (emit_ready=0) and same-cycle retires are ignored, so no underflow is flagged during flush. err_underflow is unaffected by flush.
- stall_cause: zero when emit_valid=0 or emit_ready=1; otherwise only the highest-priority failing check is set (rs1 > rs2 > rd). When flush is the only blocker, stall_cause is 0.
- busy_vec and pend_total are registered from the next-state counters, so they match the counters every cycle.

## Timing
- Reset: all counters 0, busy_vec 0, pend_total 0, err_underflow 0. emit_ready then depends only on flush.
- emit_ready and stall_cause: 0-cycle combinational paths from inputs and counters.
- Counter effect of a fire or retire is visible from the next rising edge, including in emit_ready.
- Back-to-back RAW: a producer emitted in cycle N blocks a consumer in N+1 until the cycle after its retire.
- rst asserted mid-operation clears everything immediately; pending retires after rst deassertion count as underflow.

## Configuration
- SCB_WAW_ALLOW_EN undefined: rd_ok requires cnt[rd_idx]==0, so at most one write is outstanding per register and WAW stalls.
- SCB_WAW_ALLOW_EN defined: rd_ok = !rd_vld || rd_idx==0 || cnt[rd_idx] != 2^CNT_W-1. Multiple in-flight writes to one register are allowed up to saturation, and RAW is still enforced on sources.

## Test plan
- Reset, then emit rd=5 -> cycle+1 busy_vec[5]=1, pend_total=1; a consumer with rs1=5 sees emit_ready=0 and stall_cause=3'b001.
- Retire port1 idx=5 -> next cycle busy_vec[5]=0 and the consumer emits; a same-cycle retire does not unblock.
- Emit rd=7 with retire idx=7 in the same cycle, starting from cnt=1 -> cnt[7] stays 1 and pend_total is unchanged.
- Both ports retire idx=3 with cnt[3]=1 -> cnt[3]=0 and err_underflow=1, which stays set until rst.
- With SCB_WAW_ALLOW_EN and CNT_W=2: three emits rd=4 are accepted and the fourth stalls with stall_cause=3'b100. Without the macro, the second emit stalls.
- With cnt[2]=1 and cnt[9]=2, assert flush with emit_valid and a retire -> emit_ready=0, next cycle busy_vec=0, pend_total=0, err_underflow unchanged. Emit rd=0 -> no state change.

Source files
------------

// File: rtl/core_ctrl_scb_cnt.sv
`default_nettype none
// ============================================================================
// Module   : core_ctrl_scb_cnt
// Brief    : Issue-stage register scoreboard with per-register outstanding-write
//            counters, multi-port retire, flush and observability outputs.
//            Optional macro SCB_WAW_ALLOW_EN permits multiple in-flight writes
//            per register up to counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module core_ctrl_scb_cnt #(
    parameter int NREG      = 32,
    parameter int IDX_W     = 5,
    parameter int CNT_W     = 2,
    parameter int RET_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       emit_valid,
    input  logic                       rs1_vld,
    input  logic [IDX_W-1:0]           rs1_idx,
    input  logic                       rs2_vld,
    input  logic [IDX_W-1:0]           rs2_idx,
    input  logic                       rd_vld,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic                       emit_ready,
    input  logic [RET_PORTS-1:0]       ret_valid,
    input  logic [RET_PORTS*IDX_W-1:0] ret_idx,
    input  logic                       flush,
    output logic [2:0]                 stall_cause,
    output logic [NREG-1:0]            busy_vec,
    output logic [IDX_W+CNT_W-1:0]     pend_total,
    output logic                       err_underflow
);

    localparam int c_DEC_W  = $clog2(RET_PORTS + 1);
    localparam int c_SUM_W  = CNT_W + c_DEC_W + 1;
    localparam int c_PEND_W = IDX_W + CNT_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]    r_cnt_q [1:NREG-1];
    logic [CNT_W-1:0]    w_cnt_d [1:NREG-1];
    logic [NREG-1:0]     r_busy_q;
    logic [NREG-1:0]     w_busy_d;
    logic [c_PEND_W-1:0] r_pend_q;
    logic [c_PEND_W-1:0] w_pend_d;
    logic                r_err_q;
    logic                w_err_d;

    logic [CNT_W-1:0]    w_rs1_cnt;
    logic [CNT_W-1:0]    w_rs2_cnt;
    logic [CNT_W-1:0]    w_rd_cnt;
    logic                w_rs1_ok;
    logic                w_rs2_ok;
    logic                w_rd_ok;
    logic                w_fire;
    logic                w_uf;
    logic                w_inc;
    logic [c_DEC_W-1:0]  w_dec;
    logic [c_SUM_W-1:0]  w_sum;

    // Index 0 never matches the loop, so it naturally reads as a zero counter.
    always_comb begin
        w_rs1_cnt = '0;
        w_rs2_cnt = '0;
        w_rd_cnt  = '0;
        for (int r = 1; r < NREG; r++) begin
            if (rs1_idx == IDX_W'(r)) w_rs1_cnt = r_cnt_q[r];
            if (rs2_idx == IDX_W'(r)) w_rs2_cnt = r_cnt_q[r];
            if (rd_idx  == IDX_W'(r)) w_rd_cnt  = r_cnt_q[r];
        end
    end

    assign w_rs1_ok = !rs1_vld || (w_rs1_cnt == '0);
    assign w_rs2_ok = !rs2_vld || (w_rs2_cnt == '0);
`ifdef SCB_WAW_ALLOW_EN
    assign w_rd_ok  = !rd_vld || (rd_idx == '0) || (w_rd_cnt != c_CNT_MAX);
`else
    assign w_rd_ok  = !rd_vld || (rd_idx == '0) || (w_rd_cnt == '0);
`endif

    assign emit_ready = !flush && w_rs1_ok && w_rs2_ok && w_rd_ok;
    assign w_fire     = emit_valid && emit_ready;

    always_comb begin
        stall_cause = 3'b000;
        if (emit_valid && !emit_ready) begin
            if (!w_rs1_ok)      stall_cause = 3'b001;
            else if (!w_rs2_ok) stall_cause = 3'b010;
            else if (!w_rd_ok)  stall_cause = 3'b100;
        end
    end

    // Increment and decrement are merged into one step so that an emit and a
    // retire to the same register in one cycle cancel out.
    always_comb begin
        w_uf     = 1'b0;
        w_inc    = 1'b0;
        w_dec    = '0;
        w_sum    = '0;
        w_busy_d = '0;
        w_pend_d = '0;
        for (int r = 1; r < NREG; r++) begin
            w_inc = w_fire && rd_vld && (rd_idx == IDX_W'(r));
            w_dec = '0;
            for (int p = 0; p < RET_PORTS; p++) begin
                if (ret_valid[p] && (ret_idx[p*IDX_W +: IDX_W] == IDX_W'(r)))
                    w_dec = w_dec + c_DEC_W'(1);
            end
            w_sum = c_SUM_W'(r_cnt_q[r]) + c_SUM_W'(w_inc);
            if (flush) begin
                w_cnt_d[r] = '0;
            end else if (c_SUM_W'(w_dec) > w_sum) begin
                w_cnt_d[r] = '0;
                w_uf       = 1'b1;
            end else begin
                w_cnt_d[r] = CNT_W'(w_sum - c_SUM_W'(w_dec));
            end
            w_busy_d[r] = (w_cnt_d[r] != '0);
            w_pend_d    = w_pend_d + c_PEND_W'(w_cnt_d[r]);
        end
        w_err_d = r_err_q || w_uf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) r_cnt_q[r] <= '0;
            r_busy_q <= '0;
            r_pend_q <= '0;
            r_err_q  <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) r_cnt_q[r] <= w_cnt_d[r];
            r_busy_q <= w_busy_d;
            r_pend_q <= w_pend_d;
            r_err_q  <= w_err_d;
        end
    end

    assign busy_vec      = r_busy_q;
    assign pend_total    = r_pend_q;
    assign err_underflow = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl_scb_cnt.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_ctrl_scb_cnt
// Brief    : Directed scoreboard bench for core_ctrl_scb_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_ctrl_scb_cnt;

    localparam int NREG = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 2;
    localparam int RET_PORTS = 2;

    localparam int S_RDY = 0;
    localparam int S_STL = 1;
    localparam int S_BSY = 2;
    localparam int S_PND = 3;
    localparam int S_ERR = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       emit_valid = 1'b0;
    logic                       rs1_vld = 1'b0;
    logic [IDX_W-1:0]           rs1_idx = '0;
    logic                       rs2_vld = 1'b0;
    logic [IDX_W-1:0]           rs2_idx = '0;
    logic                       rd_vld = 1'b0;
    logic [IDX_W-1:0]           rd_idx = '0;
    logic                       emit_ready;
    logic [RET_PORTS-1:0]       ret_valid = '0;
    logic [RET_PORTS*IDX_W-1:0] ret_idx = '0;
    logic                       flush = 1'b0;
    logic [2:0]                 stall_cause;
    logic [NREG-1:0]            busy_vec;
    logic [IDX_W+CNT_W-1:0]     pend_total;
    logic                       err_underflow;

    core_ctrl_scb_cnt #(
        .NREG(NREG), .IDX_W(IDX_W), .CNT_W(CNT_W), .RET_PORTS(RET_PORTS)
    ) dut (
        .clk(clk), .rst(rst), .emit_valid(emit_valid),
        .rs1_vld(rs1_vld), .rs1_idx(rs1_idx),
        .rs2_vld(rs2_vld), .rs2_idx(rs2_idx),
        .rd_vld(rd_vld), .rd_idx(rd_idx), .emit_ready(emit_ready),
        .ret_valid(ret_valid), .ret_idx(ret_idx), .flush(flush),
        .stall_cause(stall_cause), .busy_vec(busy_vec),
        .pend_total(pend_total), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic string sel_name(input int s);
        case (s)
            S_RDY:   return "emit_ready";
            S_STL:   return "stall_cause";
            S_BSY:   return "busy_vec";
            S_PND:   return "pend_total";
            default: return "err_underflow";
        endcase
    endfunction

    function automatic logic [63:0] actual(input int s);
        case (s)
            S_RDY:   return 64'(emit_ready);
            S_STL:   return 64'(stall_cause);
            S_BSY:   return 64'(busy_vec);
            S_PND:   return 64'(pend_total);
            default: return 64'(err_underflow);
        endcase
    endfunction

    // dcyc=0: value visible this cycle; dcyc=1: visible after the next edge.
    task automatic push(input int dcyc, input int sel, input logic [63:0] v);
        exp_t e;
        e.cyc = cyc + dcyc;
        e.sel = sel;
        e.exp = v;
        q.push_back(e);
    endtask

    task automatic now(input int sel, input logic [63:0] v);
        push(0, sel, v);
    endtask

    task automatic nxt(input int sel, input logic [63:0] v);
        push(1, sel, v);
    endtask

    task automatic drive(input logic ev, input logic r1v, input int r1,
                         input logic r2v, input int r2,
                         input logic rdv, input int rd,
                         input logic [1:0] rv, input int ri0, input int ri1,
                         input logic fl);
        @(posedge clk);
        #1;
        emit_valid = ev;
        rs1_vld    = r1v;
        rs1_idx    = IDX_W'(r1);
        rs2_vld    = r2v;
        rs2_idx    = IDX_W'(r2);
        rd_vld     = rdv;
        rd_idx     = IDX_W'(rd);
        ret_valid  = rv;
        ret_idx    = {IDX_W'(ri1), IDX_W'(ri0)};
        flush      = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    task automatic emit_rd(input int rd);
        drive(1, 0, 0, 0, 0, 1, rd, 2'b00, 0, 0, 0);
    endtask

    initial begin
        exp_t        e;
        logic [63:0] act;

        fork
            forever begin
                @(negedge clk);
                while (q.size() > 0 && q[0].cyc <= cyc) begin
                    e   = q.pop_front();
                    act = actual(e.sel);
                    n_chk++;
                    if (act !== e.exp) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                                 sel_name(e.sel), act, e.exp, cyc);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Post-reset state
        idle();
        now(S_RDY, 1); now(S_STL, 0); now(S_BSY, 0); now(S_PND, 0); now(S_ERR, 0);

        // Producer rd=5
        emit_rd(5);
        now(S_RDY, 1); nxt(S_BSY, 64'h20); nxt(S_PND, 1);

        // RAW on both sources (rs1 wins); same-cycle retire on port1 does not unblock
        drive(1, 1, 5, 1, 5, 1, 6, 2'b10, 0, 5, 0);
        now(S_RDY, 0); now(S_STL, 3'b001); nxt(S_BSY, 0); nxt(S_PND, 0);

        // Consumer now emits, writing r6
        drive(1, 1, 5, 0, 0, 1, 6, 2'b00, 0, 0, 0);
        now(S_RDY, 1); now(S_STL, 0); nxt(S_BSY, 64'h40); nxt(S_PND, 1);

        // rs2 blocker
        drive(1, 1, 1, 1, 6, 1, 8, 2'b00, 0, 0, 0);
        now(S_RDY, 0); now(S_STL, 3'b010); nxt(S_BSY, 64'h40);

        // No emit_valid -> no stall cause reported
        drive(0, 1, 6, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        now(S_RDY, 0); now(S_STL, 0);

        // Retire r6 on port0
        drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 6, 0, 0);
        nxt(S_BSY, 0); nxt(S_PND, 0);

        // cnt[7]=1 then emit rd=7 with a same-cycle retire of r7
        emit_rd(7);
        nxt(S_BSY, 64'h80); nxt(S_PND, 1);
        drive(1, 0, 0, 0, 0, 1, 7, 2'b01, 7, 0, 0);
`ifdef SCB_WAW_ALLOW_EN
        now(S_RDY, 1); nxt(S_BSY, 64'h80); nxt(S_PND, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0);
        nxt(S_BSY, 0); nxt(S_PND, 0);
`else
        now(S_RDY, 0); now(S_STL, 3'b100); nxt(S_BSY, 0); nxt(S_PND, 0);
`endif

        // Double retire of r3 with cnt=1 -> underflow, sticky
        emit_rd(3);
        nxt(S_BSY, 64'h8); nxt(S_PND, 1); nxt(S_ERR, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 2'b11, 3, 3, 0);
        nxt(S_BSY, 0); nxt(S_PND, 0); nxt(S_ERR, 1);
        idle();
        nxt(S_ERR, 1);

        // Build cnt[2]=1, cnt[9]=1 (2 with WAW) then flush with emit and retire
        emit_rd(2);
        emit_rd(9);
`ifdef SCB_WAW_ALLOW_EN
        emit_rd(9);
        nxt(S_PND, 3);
`else
        nxt(S_PND, 2);
`endif
        nxt(S_BSY, 64'h204);
        drive(1, 0, 0, 0, 0, 1, 10, 2'b01, 2, 0, 1);
        now(S_RDY, 0); now(S_STL, 0); nxt(S_BSY, 0); nxt(S_PND, 0); nxt(S_ERR, 1);

        // Emit rd=0 is accepted and leaves state untouched
        emit_rd(0);
        now(S_RDY, 1); nxt(S_BSY, 0); nxt(S_PND, 0);

        // WAW limit on r4
        emit_rd(4);
        now(S_RDY, 1);
`ifdef SCB_WAW_ALLOW_EN
        emit_rd(4);
        now(S_RDY, 1);
        emit_rd(4);
        now(S_RDY, 1);
        emit_rd(4);
        now(S_RDY, 0); now(S_STL, 3'b100); nxt(S_PND, 3); nxt(S_BSY, 64'h10);
`else
        emit_rd(4);
        now(S_RDY, 0); now(S_STL, 3'b100); nxt(S_PND, 1); nxt(S_BSY, 64'h10);
`endif
        idle();

        // Asynchronous reset mid-operation, then a stale retire underflows
        idle();
        rst = 1'b1;
        now(S_BSY, 0); now(S_PND, 0); now(S_ERR, 0);
        idle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 4, 0, 0);
        nxt(S_ERR, 1); nxt(S_PND, 0);
        idle();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
